mem_stage_lsu: RTL and testbench

Parametrised load/store unit for the Memory (M) stage of the 4-stage pipeline. It extends the combinational M-stage load-select decode with a request/grant/response handshake to a variable-latency data memory. It also generates store byte masks, formats load data for any supported width, detects misaligned accesses and stalls the pipeline until each access completes. It sits between the M-stage pipeline register and DMEM, and its `ld_data` output feeds writeback.

---
 rtl/mem_stage_lsu.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: decode, store lane masks, load formatting and DMEM handshake FSM.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W/D accesses instead of truncating the offset.
module mem_stage_lsu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst_M,
    input  logic              valid_M,
    input  logic              flush_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [DATA_W-1:0] st_data_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [STRB_W-1:0] dmem_wmask,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] ld_data,
    output logic              stall_M,
    output logic              misalign
);
    localparam int unsigned LANE_W = $clog2(STRB_W);
    localparam bit          HAS64  = (DATA_W == 64);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [STRB_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
        logic [LANE_W-1:0] lane;
        logic [2:0]        funct3;
    } req_t;

    state_e            state_q, state_d;
    req_t              req_q, req_d, req_c, req_out;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [1:0]        size;
    logic              is_load, is_store, legal, mis, mem_live, issue, trap;
    logic [LANE_W-1:0] lane_raw, lane_keep, lane;
    logic [DATA_W-1:0] rd_shift, ld_fmt;

    assign opcode   = inst_M[6:0];
    assign funct3   = inst_M[14:12];
    assign size     = funct3[1:0];
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);

    logic unused_inst;
    assign unused_inst = ^{inst_M[31:15], inst_M[11:7]};

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = is_load | is_store;
            3'b011:                 legal = (is_load | is_store) & HAS64;
            3'b100, 3'b101:         legal = is_load;
            3'b110:                 legal = is_load & HAS64;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_M[0];
            2'd2:    mis = |addr_M[1:0];
            default: mis = |addr_M[2:0];
        endcase
    end

    assign mem_live = valid_M & legal & ~flush_M;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap  = mem_live & mis;
    assign issue = mem_live & ~mis;
`else
    logic unused_mis;
    assign unused_mis = mis;
    assign trap       = 1'b0;
    assign issue      = mem_live;
`endif

    // Offset bits below the access size are dropped, so a misaligned access lands on its container.
    assign lane_raw  = addr_M[LANE_W-1:0];
    assign lane_keep = {LANE_W{1'b1}} << size;
    assign lane      = lane_raw & lane_keep;

    always_comb begin
        req_c        = '0;
        req_c.addr   = {addr_M[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        req_c.we     = is_store;
        req_c.lane   = lane;
        req_c.funct3 = funct3;
        if (is_store) begin
            case (size)
                2'd0: begin
                    req_c.wmask = STRB_W'(1) << lane;
                    req_c.wdata = {STRB_W{st_data_M[7:0]}};
                end
                2'd1: begin
                    req_c.wmask = STRB_W'(3) << lane;
                    req_c.wdata = {(STRB_W / 2){st_data_M[15:0]}};
                end
                2'd2: begin
                    req_c.wmask = STRB_W'(15) << lane;
                    req_c.wdata = {(STRB_W / 4){st_data_M[31:0]}};
                end
                default: begin
                    req_c.wmask = '1;
                    req_c.wdata = st_data_M;
                end
            endcase
        end
    end

    assign rd_shift = dmem_rdata >> {req_q.lane, 3'b000};

    always_comb begin
        case (req_q.funct3)
            3'b000:  ld_fmt = DATA_W'($signed(rd_shift[7:0]));
            3'b001:  ld_fmt = DATA_W'($signed(rd_shift[15:0]));
            3'b010:  ld_fmt = DATA_W'($signed(rd_shift[31:0]));
            3'b100:  ld_fmt = DATA_W'(rd_shift[7:0]);
            3'b101:  ld_fmt = DATA_W'(rd_shift[15:0]);
            3'b110:  ld_fmt = DATA_W'(rd_shift[31:0]);
            default: ld_fmt = rd_shift;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        discard_d = discard_q;
        ld_data_d = ld_data_q;
        req_out   = '0;
        dmem_req  = 1'b0;
        stall_M   = 1'b0;
        misalign  = 1'b0;
        unique case (state_q)
            StIdle: begin
                misalign = trap;
                if (issue) begin
                    stall_M   = 1'b1;
                    dmem_req  = 1'b1;
                    req_out   = req_c;
                    req_d     = req_c;
                    discard_d = 1'b0;
                    if (dmem_gnt) begin
                        state_d = req_c.we ? StDone : StWait;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                stall_M = 1'b1;
                if (flush_M) begin
                    state_d = StIdle;
                end else begin
                    dmem_req = 1'b1;
                    req_out  = req_q;
                    if (dmem_gnt) begin
                        state_d = req_q.we ? StDone : StWait;
                    end
                end
            end
            StWait: begin
                // A granted load always drains its response, even when flushed.
                stall_M = 1'b1;
                if (dmem_rvalid) begin
                    discard_d = 1'b0;
                    if (discard_q | flush_M) begin
                        state_d = StIdle;
                    end else begin
                        ld_data_d = ld_fmt;
                        state_d   = StDone;
                    end
                end else if (flush_M) begin
                    discard_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        dmem_we    = req_out.we;
        dmem_addr  = req_out.addr;
        dmem_wmask = req_out.wmask;
        dmem_wdata = req_out.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_q     <= '0;
            discard_q <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            discard_q <= discard_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign ld_data = ld_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: 32-bit and 64-bit instances share stimulus, one is observed.
module tb_mem_stage_lsu;
    localparam logic [31:0] INST_SB  = 32'h00000023;
    localparam logic [31:0] INST_SH  = 32'h00001023;
    localparam logic [31:0] INST_SD  = 32'h00003023;
    localparam logic [31:0] INST_LH  = 32'h00001003;
    localparam logic [31:0] INST_LW  = 32'h00002003;
    localparam logic [31:0] INST_LD  = 32'h00003003;
    localparam logic [31:0] INST_LHU = 32'h00005003;
    localparam logic [31:0] INST_LWU = 32'h00006003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_M;
    logic        valid_M, flush_M;
    logic [31:0] addr_M;
    logic [63:0] st_data_M;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata;

    logic        req32, we32, stall32, mis32;
    logic [31:0] daddr32, wdata32, ld32;
    logic [3:0]  wmask32;
    logic        req64, we64, stall64, mis64;
    logic [31:0] daddr64;
    logic [63:0] wdata64, ld64;
    logic [7:0]  wmask64;

    logic        sel64;
    logic        obs_req, obs_we, obs_stall, obs_mis;
    logic [31:0] obs_addr;
    logic [7:0]  obs_wmask;
    logic [63:0] obs_wdata, obs_ld;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .inst_M(inst_M), .valid_M(valid_M), .flush_M(flush_M),
        .addr_M(addr_M), .st_data_M(st_data_M[31:0]), .dmem_req(req32), .dmem_we(we32),
        .dmem_addr(daddr32), .dmem_wmask(wmask32), .dmem_wdata(wdata32), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata[31:0]), .ld_data(ld32),
        .stall_M(stall32), .misalign(mis32)
    );

    mem_stage_lsu #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .inst_M(inst_M), .valid_M(valid_M), .flush_M(flush_M),
        .addr_M(addr_M), .st_data_M(st_data_M), .dmem_req(req64), .dmem_we(we64),
        .dmem_addr(daddr64), .dmem_wmask(wmask64), .dmem_wdata(wdata64), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .ld_data(ld64),
        .stall_M(stall64), .misalign(mis64)
    );

    always_comb begin
        if (sel64) begin
            obs_req = req64; obs_we = we64; obs_stall = stall64; obs_mis = mis64;
            obs_addr = daddr64; obs_wmask = wmask64; obs_wdata = wdata64; obs_ld = ld64;
        end else begin
            obs_req = req32; obs_we = we32; obs_stall = stall32; obs_mis = mis32;
            obs_addr = daddr32; obs_wmask = {4'b0, wmask32};
            obs_wdata = {32'b0, wdata32}; obs_ld = {32'b0, ld32};
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access to completion; grant comes gnt_dly cycles after issue, rvalid rv_dly later.
    task automatic do_access(input logic [31:0] inst, input logic [31:0] addr,
                             input logic [63:0] wd, input int gnt_dly, input int rv_dly,
                             input logic [63:0] rdata, output int stalls,
                             output logic [31:0] g_addr, output logic [7:0] g_mask,
                             output logic [63:0] g_wdata, output logic g_req,
                             output logic g_mis);
        inst_M = inst; addr_M = addr; st_data_M = wd; dmem_rdata = rdata;
        valid_M = 1'b1; flush_M = 1'b0;
        stalls = 0; g_addr = '0; g_mask = '0; g_wdata = '0; g_req = 1'b0; g_mis = 1'b0;
        for (int c = 0; c < 20; c++) begin
            dmem_gnt    = (c == gnt_dly);
            dmem_rvalid = (c == gnt_dly + rv_dly);
            @(negedge clk);
            if (c == 0) g_mis = obs_mis;
            if (c == gnt_dly) begin
                g_req = obs_req; g_addr = obs_addr; g_mask = obs_wmask; g_wdata = obs_wdata;
            end
            if (!obs_stall) break;
            stalls++;
            step();
        end
        step();
        valid_M = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          st;
        logic [31:0] ga;
        logic [7:0]  gm;
        logic [63:0] gw;
        logic        gr, gmis;

        sel64 = 1'b0; rst_n = 1'b0; inst_M = '0; valid_M = 1'b0; flush_M = 1'b0;
        addr_M = '0; st_data_M = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #12;
        check_eq("rst_req", obs_req, 0);
        check_eq("rst_stall", obs_stall, 0);
        check_eq("rst_ld", obs_ld, 0);
        check_eq("rst_mis", obs_mis, 0);
        rst_n = 1'b1;
        step();

        do_access(INST_SB, 32'h1003, 64'hAABBCCDD, 0, 1, 64'h0, st, ga, gm, gw, gr, gmis);
        check_eq("sb_stall", st, 1);
        check_eq("sb_req", gr, 1);
        check_eq("sb_addr", ga, 32'h1000);
        check_eq("sb_mask", gm, 8'h8);
        check_eq("sb_wdata", gw, 64'hDDDDDDDD);

        do_access(INST_SH, 32'h1002, 64'hAABBCCDD, 0, 1, 64'h0, st, ga, gm, gw, gr, gmis);
        check_eq("sh_mask", gm, 8'hC);
        check_eq("sh_wdata", gw, 64'hCCDDCCDD);

        do_access(INST_LH, 32'h2002, 64'h0, 2, 1, 64'h80FF1234, st, ga, gm, gw, gr, gmis);
        check_eq("lh_stall", st, 4);
        check_eq("lh_req_at_gnt", gr, 1);
        check_eq("lh_addr_at_gnt", ga, 32'h2000);
        check_eq("lh_data", obs_ld, 64'hFFFF80FF);

        do_access(INST_LHU, 32'h2002, 64'h0, 2, 1, 64'h80FF1234, st, ga, gm, gw, gr, gmis);
        check_eq("lhu_stall", st, 4);
        check_eq("lhu_data", obs_ld, 64'h000080FF);

        // Flush while waiting for the response: data discarded, FSM idle right after rvalid.
        inst_M = INST_LW; addr_M = 32'h40; valid_M = 1'b1; flush_M = 1'b0;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 64'h12345678;
        @(negedge clk);
        check_eq("fl_req", obs_req, 1);
        step();
        dmem_gnt = 1'b0; flush_M = 1'b1;
        @(negedge clk);
        check_eq("fl_wait_stall", obs_stall, 1);
        step();
        flush_M = 1'b0; valid_M = 1'b0; dmem_rvalid = 1'b1;
        @(negedge clk);
        check_eq("fl_rvalid_stall", obs_stall, 1);
        step();
        dmem_rvalid = 1'b0; inst_M = INST_SB; addr_M = 32'h60; valid_M = 1'b1;
        @(negedge clk);
        check_eq("fl_idle_issue", obs_req, 1);
        check_eq("fl_ld_kept", obs_ld, 64'h000080FF);
        step();
        flush_M = 1'b1;
        @(negedge clk);
        check_eq("fl_req_drop", obs_req, 0);
        step();
        flush_M = 1'b0; valid_M = 1'b0;
        @(negedge clk);
        check_eq("fl_back_idle_stall", obs_stall, 0);
        check_eq("fl_back_idle_req", obs_req, 0);
        step();

        sel64 = 1'b1;
        do_access(INST_LD, 32'h10, 64'h0, 0, 1, 64'hFFFFFFFF_80000000, st, ga, gm, gw, gr, gmis);
        check_eq("ld_stall", st, 2);
        check_eq("ld_addr", ga, 32'h10);
        check_eq("ld_data", obs_ld, 64'hFFFFFFFF_80000000);
        do_access(INST_LWU, 32'h10, 64'h0, 0, 1, 64'hFFFFFFFF_80000000, st, ga, gm, gw, gr, gmis);
        check_eq("lwu_data", obs_ld, 64'h00000000_80000000);
        do_access(INST_SD, 32'h18, 64'h11223344_55667788, 0, 1, 64'h0, st, ga, gm, gw, gr, gmis);
        check_eq("sd_stall", st, 1);
        check_eq("sd_mask", gm, 8'hFF);
        check_eq("sd_wdata", gw, 64'h11223344_55667788);
        sel64 = 1'b0;

        do_access(INST_LW, 32'h3002, 64'h0, 0, 1, 64'h11223344, st, ga, gm, gw, gr, gmis);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("mis_pulse", gmis, 1);
        check_eq("mis_no_req", gr, 0);
        check_eq("mis_no_stall", st, 0);
`else
        check_eq("mis_tied", gmis, 0);
        check_eq("mis_addr", ga, 32'h3000);
        check_eq("mis_stall", st, 2);
        check_eq("mis_data", obs_ld, 64'h11223344);
`endif

        // Reset in the middle of a load wait.
        inst_M = INST_LW; addr_M = 32'h50; valid_M = 1'b1; dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        check_eq("rw_stall_pre", obs_stall, 1);
        rst_n = 1'b0; valid_M = 1'b0;
        #1;
        check_eq("rw_req", obs_req, 0);
        check_eq("rw_we", obs_we, 0);
        check_eq("rw_addr", obs_addr, 0);
        check_eq("rw_mask", obs_wmask, 0);
        check_eq("rw_wdata", obs_wdata, 0);
        check_eq("rw_ld", obs_ld, 0);
        check_eq("rw_stall", obs_stall, 0);
        check_eq("rw_mis", obs_mis, 0);
        #2;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_req", obs_req, 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
